// File: rtl/exc_pkg.sv
// Shared definitions for the exception commit unit: ExcCodes, flag bit
// positions, data-TLB fault kinds, default vectors and FSM states.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int B_IF_ADEL   = 0;
    localparam int B_IF_REFILL = 1;
    localparam int B_IF_INV    = 2;
    localparam int B_RI        = 3;
    localparam int B_OV        = 4;
    localparam int B_SYS       = 5;
    localparam int B_BP        = 6;
    localparam int B_D_ADEL    = 7;
    localparam int B_D_ADES    = 8;
    localparam int B_D_TLB     = 9;

    localparam logic [1:0] DTLB_REFILL = 2'd0;
    localparam logic [1:0] DTLB_INV    = 2'd1;
    localparam logic [1:0] DTLB_MOD    = 2'd2;

    localparam logic [31:0] EXC_VECTOR_DEF    = 32'hBFC0_0380;
    localparam logic [31:0] REFILL_VECTOR_DEF = 32'hBFC0_0200;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_UPDATE   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 / fetch-redirect signal bundle around the commit unit.
// slave: the commit unit itself; master: the surrounding pipeline and CP0.
interface exc_ctrl_if;
    logic        mem_valid;
    logic        mem_stall;
    logic [31:0] mem_pc;
    logic        mem_in_ds;
    logic [9:0]  mem_exc;
    logic [1:0]  mem_dtlb_kind;
    logic        mem_is_store;
    logic        mem_eret;
    logic [31:0] mem_badvaddr;
    logic        cp0_has_int;
    logic        cp0_exl;
    logic [31:0] cp0_epc;
    logic        mem_kill;
    logic        w_cp0_update_ena;
    logic [4:0]  w_cp0_exccode;
    logic        w_cp0_bd;
    logic        w_cp0_exl;
    logic [31:0] w_cp0_epc;
    logic        w_cp0_badvaddr_ena;
    logic [31:0] w_cp0_badvaddr;
    logic        w_cp0_entryhi_ena;
    logic [31:0] w_cp0_entryhi;
    logic        cp0_cls_exl;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport slave (
        input  mem_valid, mem_stall, mem_pc, mem_in_ds, mem_exc, mem_dtlb_kind,
               mem_is_store, mem_eret, mem_badvaddr, cp0_has_int, cp0_exl,
               cp0_epc, redirect_ready,
        output mem_kill, w_cp0_update_ena, w_cp0_exccode, w_cp0_bd, w_cp0_exl,
               w_cp0_epc, w_cp0_badvaddr_ena, w_cp0_badvaddr, w_cp0_entryhi_ena,
               w_cp0_entryhi, cp0_cls_exl, flush, redirect_valid, redirect_pc
    );

    modport master (
        output mem_valid, mem_stall, mem_pc, mem_in_ds, mem_exc, mem_dtlb_kind,
               mem_is_store, mem_eret, mem_badvaddr, cp0_has_int, cp0_exl,
               cp0_epc, redirect_ready,
        input  mem_kill, w_cp0_update_ena, w_cp0_exccode, w_cp0_bd, w_cp0_exl,
               w_cp0_epc, w_cp0_badvaddr_ena, w_cp0_badvaddr, w_cp0_entryhi_ena,
               w_cp0_entryhi, cp0_cls_exl, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_prio.sv
// Priority encoder: picks the winning exception and decides which address
// (fetch PC or data address) goes to BadVAddr/EntryHi.
module exc_prio
    import exc_pkg::*;
(
    input  logic        i_int,
    input  logic [9:0]  i_exc,
    input  logic [1:0]  i_dtlb_kind,
    input  logic        i_is_store,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_badvaddr,
    output logic        o_hit,
    output logic [4:0]  o_code,
    output logic        o_bva_ena,
    output logic [31:0] o_bva,
    output logic        o_ehi_ena,
    output logic        o_refill
);

    // Highest-priority event wins; fetch faults report the PC as the bad address.
    always_comb begin
        o_hit     = 1'b1;
        o_code    = EXC_INT;
        o_bva_ena = 1'b0;
        o_bva     = i_badvaddr;
        o_ehi_ena = 1'b0;
        o_refill  = 1'b0;
        if (i_int) begin
            o_code = EXC_INT;
        end else if (i_exc[B_IF_ADEL]) begin
            o_code    = EXC_ADEL;
            o_bva_ena = 1'b1;
            o_bva     = i_pc;
        end else if (i_exc[B_IF_REFILL] | i_exc[B_IF_INV]) begin
            o_code    = EXC_TLBL;
            o_bva_ena = 1'b1;
            o_bva     = i_pc;
            o_ehi_ena = 1'b1;
            o_refill  = i_exc[B_IF_REFILL];
        end else if (i_exc[B_RI]) begin
            o_code = EXC_RI;
        end else if (i_exc[B_OV]) begin
            o_code = EXC_OV;
        end else if (i_exc[B_SYS]) begin
            o_code = EXC_SYS;
        end else if (i_exc[B_BP]) begin
            o_code = EXC_BP;
        end else if (i_exc[B_D_ADEL]) begin
            o_code    = EXC_ADEL;
            o_bva_ena = 1'b1;
        end else if (i_exc[B_D_ADES]) begin
            o_code    = EXC_ADES;
            o_bva_ena = 1'b1;
        end else if (i_exc[B_D_TLB]) begin
            o_bva_ena = 1'b1;
            o_ehi_ena = 1'b1;
            if (i_dtlb_kind == DTLB_MOD) begin
                o_code = EXC_MOD;
            end else begin
                o_code   = i_is_store ? EXC_TLBS : EXC_TLBL;
                o_refill = (i_dtlb_kind == DTLB_REFILL);
            end
        end else begin
            o_hit = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt commit unit at MEM: drives the CP0 exception update,
// flushes the pipeline and offers a redirect PC to fetch.
//
//   state       | meaning
//   ST_IDLE     | watching MEM for a committable event
//   ST_UPDATE   | one-cycle CP0 update / clear-EXL strobe, redirect offered
//   ST_REDIRECT | holding flush and redirect until fetch accepts
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
    parameter logic [31:0] REFILL_VECTOR = REFILL_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    exc_ctrl_if.slave   bus
);

    state_t      r_state;
    logic        r_int_pend;
    logic        r_int_d;
    logic        r_upd;
    logic        r_cls;
    logic [4:0]  r_code;
    logic        r_bd;
    logic [31:0] r_epc;
    logic        r_bva_ena;
    logic [31:0] r_bva;
    logic        r_ehi_ena;
    logic [31:0] r_ehi;
    logic        r_flush;
    logic        r_rv;
    logic [31:0] r_rpc;

    logic        w_commit;
    logic        w_int_take;
    logic        w_hit;
    logic [4:0]  w_code;
    logic        w_bva_ena;
    logic [31:0] w_bva;
    logic        w_ehi_ena;
    logic        w_refill;
    logic        w_is_eret;
    logic        w_go;
    logic [31:0] w_epc;
    logic [31:0] w_target;

    exc_prio u_prio (
        .i_int       (w_int_take),
        .i_exc       (bus.mem_exc),
        .i_dtlb_kind (bus.mem_dtlb_kind),
        .i_is_store  (bus.mem_is_store),
        .i_pc        (bus.mem_pc),
        .i_badvaddr  (bus.mem_badvaddr),
        .o_hit       (w_hit),
        .o_code      (w_code),
        .o_bva_ena   (w_bva_ena),
        .o_bva       (w_bva),
        .o_ehi_ena   (w_ehi_ena),
        .o_refill    (w_refill)
    );

    assign w_commit   = bus.mem_valid & ~bus.mem_stall;
    assign w_int_take = bus.cp0_has_int | r_int_pend;
    // ERET only counts when nothing (interrupt included) outranks it.
    assign w_is_eret  = bus.mem_eret & ~w_hit;
    assign w_go       = (r_state == ST_IDLE) & w_commit & (w_hit | w_is_eret);
    assign w_epc      = bus.mem_in_ds ? (bus.mem_pc - 32'd4) : bus.mem_pc;
    assign w_target   = w_is_eret ? bus.cp0_epc :
                        ((w_refill & ~bus.cp0_exl) ? REFILL_VECTOR : EXC_VECTOR);

    assign bus.mem_kill           = w_go;
    assign bus.w_cp0_update_ena   = r_upd;
    assign bus.w_cp0_exl          = r_upd;
    assign bus.w_cp0_exccode      = r_code;
    assign bus.w_cp0_bd           = r_bd;
    assign bus.w_cp0_epc          = r_epc;
    assign bus.w_cp0_badvaddr_ena = r_bva_ena;
    assign bus.w_cp0_badvaddr     = r_bva;
    assign bus.w_cp0_entryhi_ena  = r_ehi_ena;
    assign bus.w_cp0_entryhi      = r_ehi;
    assign bus.cp0_cls_exl        = r_cls;
    assign bus.flush              = r_flush;
    assign bus.redirect_valid     = r_rv;
    assign bus.redirect_pc        = r_rpc;

    // Remember an interrupt edge that arrived with no instruction to attach it to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_d    <= 1'b0;
            r_int_pend <= 1'b0;
        end else begin
            r_int_d <= bus.cp0_has_int;
            if ((w_go & w_int_take) |
                ((r_state == ST_UPDATE) & ~bus.redirect_ready)) begin
                r_int_pend <= 1'b0;
            end else if (bus.cp0_has_int & ~r_int_d) begin
                r_int_pend <= 1'b1;
            end
        end
    end

    // Commit FSM with registered CP0 strobes and redirect handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_upd     <= 1'b0;
            r_cls     <= 1'b0;
            r_code    <= 5'd0;
            r_bd      <= 1'b0;
            r_epc     <= 32'd0;
            r_bva_ena <= 1'b0;
            r_bva     <= 32'd0;
            r_ehi_ena <= 1'b0;
            r_ehi     <= 32'd0;
            r_flush   <= 1'b0;
            r_rv      <= 1'b0;
            r_rpc     <= 32'd0;
        end else begin
            r_upd     <= 1'b0;
            r_cls     <= 1'b0;
            r_bva_ena <= 1'b0;
            r_ehi_ena <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_state <= ST_UPDATE;
                        r_flush <= 1'b1;
                        r_rv    <= 1'b1;
                        r_rpc   <= w_target;
                        r_cls   <= w_is_eret;
                        r_upd   <= ~w_is_eret;
                        if (!w_is_eret) begin
                            r_code    <= w_code;
                            r_bd      <= bus.mem_in_ds;
                            r_epc     <= w_epc;
                            r_bva_ena <= w_bva_ena;
                            r_bva     <= w_bva;
                            r_ehi_ena <= w_ehi_ena;
                            r_ehi     <= {w_bva[31:13], 13'h0};
                        end
                    end
                end
                ST_UPDATE, ST_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        r_state <= ST_IDLE;
                        r_flush <= 1'b0;
                        r_rv    <= 1'b0;
                    end else begin
                        r_state <= ST_REDIRECT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed cases followed by randomized transactions,
// each checked against a flag-to-ExcCode reference model.
module tb_exc_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    exc_ctrl_if bus ();

    exc_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference expectations
    logic        m_pend;
    logic        e_kill, e_is_exc, e_is_eret, e_bva_ena, e_ehi_ena;
    logic [4:0]  e_code;
    logic [31:0] e_epc, e_bva, e_ehi, e_tgt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Priority order is the flag bit order; interrupt sits above all of it.
    task automatic predict();
        int     lb;
        logic   int_t, commit, fetch, refill;
        logic [4:0] code;
        lb = -1;
        for (int b = 9; b >= 0; b--) if (bus.mem_exc[b]) lb = b;
        int_t  = bus.cp0_has_int | m_pend;
        commit = bus.mem_valid & ~bus.mem_stall;
        fetch  = 1'b0;
        refill = 1'b0;
        code   = 5'd0;
        if (!int_t) begin
            case (lb)
                0: begin code = 5'd4; fetch = 1'b1; end
                1: begin code = 5'd2; fetch = 1'b1; refill = 1'b1; end
                2: begin code = 5'd2; fetch = 1'b1; end
                3: code = 5'd10;
                4: code = 5'd12;
                5: code = 5'd8;
                6: code = 5'd9;
                7: code = 5'd4;
                8: code = 5'd5;
                9: begin
                    if (bus.mem_dtlb_kind == 2'd2) code = 5'd1;
                    else code = bus.mem_is_store ? 5'd3 : 5'd2;
                    refill = (bus.mem_dtlb_kind == 2'd0);
                end
                default: code = 5'd0;
            endcase
        end
        e_is_exc  = commit & (int_t | (lb >= 0));
        e_is_eret = commit & ~int_t & (lb < 0) & bus.mem_eret;
        e_kill    = e_is_exc | e_is_eret;
        e_code    = code;
        e_bva_ena = !int_t && (code inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5});
        e_ehi_ena = !int_t && (code inside {5'd1, 5'd2, 5'd3});
        e_bva     = fetch ? bus.mem_pc : bus.mem_badvaddr;
        e_ehi     = e_bva & 32'hFFFF_E000;
        e_epc     = bus.mem_in_ds ? bus.mem_pc - 32'd4 : bus.mem_pc;
        e_tgt     = e_is_eret ? bus.cp0_epc :
                    ((refill && !bus.cp0_exl) ? 32'hBFC0_0200 : 32'hBFC0_0380);
    endtask

    task automatic set_in(input logic valid, input logic stall, input logic [31:0] pc,
                          input logic ds, input logic [9:0] exc, input logic [1:0] kind,
                          input logic store, input logic eret, input logic [31:0] bva,
                          input logic hint, input logic exl, input logic [31:0] epc);
        bus.mem_valid     = valid;
        bus.mem_stall     = stall;
        bus.mem_pc        = pc;
        bus.mem_in_ds     = ds;
        bus.mem_exc       = exc;
        bus.mem_dtlb_kind = kind;
        bus.mem_is_store  = store;
        bus.mem_eret      = eret;
        bus.mem_badvaddr  = bva;
        bus.cp0_has_int   = hint;
        bus.cp0_exl       = exl;
        bus.cp0_epc       = epc;
    endtask

    task automatic clr_in();
        bus.mem_valid   = 1'b0;
        bus.mem_exc     = 10'd0;
        bus.mem_eret    = 1'b0;
        bus.cp0_has_int = 1'b0;
    endtask

    // Inputs already applied in IDLE; walks N, UPDATE, REDIRECT and handshake.
    task automatic run_txn(input string tag, input int lat);
        logic [31:0] tgt;
        predict();
        tgt = e_tgt;
        #1;
        chk({tag, ".kill"}, 32'(bus.mem_kill), 32'(e_kill));
        @(posedge clk); #1;
        clr_in();
        m_pend = 1'b0;
        if (!e_kill) begin
            chk({tag, ".noupd"}, 32'(bus.w_cp0_update_ena), 32'd0);
            chk({tag, ".norv"}, 32'(bus.redirect_valid), 32'd0);
        end else begin
            chk({tag, ".upd"}, 32'(bus.w_cp0_update_ena), 32'(e_is_exc));
            chk({tag, ".cls"}, 32'(bus.cp0_cls_exl), 32'(e_is_eret));
            chk({tag, ".flush"}, 32'(bus.flush), 32'd1);
            chk({tag, ".rv"}, 32'(bus.redirect_valid), 32'd1);
            chk({tag, ".rpc"}, bus.redirect_pc, tgt);
            chk({tag, ".bvaena"}, 32'(bus.w_cp0_badvaddr_ena), 32'(e_is_exc & e_bva_ena));
            chk({tag, ".ehiena"}, 32'(bus.w_cp0_entryhi_ena), 32'(e_is_exc & e_ehi_ena));
            if (e_is_exc) begin
                chk({tag, ".code"}, 32'(bus.w_cp0_exccode), 32'(e_code));
                chk({tag, ".epc"}, bus.w_cp0_epc, e_epc);
                chk({tag, ".exl"}, 32'(bus.w_cp0_exl), 32'd1);
                if (e_bva_ena) chk({tag, ".bva"}, bus.w_cp0_badvaddr, e_bva);
                if (e_ehi_ena) chk({tag, ".ehi"}, bus.w_cp0_entryhi, e_ehi);
            end
            for (int k = 0; k < lat; k++) begin
                bus.redirect_ready = 1'b0;
                @(posedge clk); #1;
                chk({tag, ".hold_upd"}, 32'(bus.w_cp0_update_ena | bus.cp0_cls_exl), 32'd0);
                chk({tag, ".hold_rv"}, 32'(bus.redirect_valid & bus.flush), 32'd1);
                chk({tag, ".hold_rpc"}, bus.redirect_pc, tgt);
            end
            bus.redirect_ready = 1'b1;
            @(posedge clk); #1;
            bus.redirect_ready = 1'b0;
            chk({tag, ".done_rv"}, 32'(bus.redirect_valid | bus.flush), 32'd0);
            chk({tag, ".done_upd"}, 32'(bus.w_cp0_update_ena), 32'd0);
        end
    endtask

    initial begin
        logic [9:0] exc;
        logic       valid, stall, hint;
        n_tests = 0;
        n_fail  = 0;
        m_pend  = 1'b0;
        rst     = 1'b1;
        bus.redirect_ready = 1'b0;
        set_in(0, 0, 32'h0, 0, 10'h0, 2'd0, 0, 0, 32'h0, 0, 0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset.out", 32'({bus.mem_kill, bus.w_cp0_update_ena, bus.cp0_cls_exl,
                              bus.flush, bus.redirect_valid, bus.w_cp0_badvaddr_ena,
                              bus.w_cp0_entryhi_ena}), 32'd0);
        chk("reset.rpc", bus.redirect_pc, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        set_in(1, 0, 32'h8000_1000, 0, 10'h010, 2'd0, 0, 0, 32'h0, 0, 0, 32'h0);
        run_txn("ov", 3);
        set_in(1, 0, 32'h8000_2004, 1, 10'h100, 2'd0, 1, 0, 32'h3, 0, 0, 32'h0);
        run_txn("ades", 1);
        set_in(1, 0, 32'h8000_0100, 0, 10'h200, 2'd0, 0, 0, 32'h1234_5678, 0, 0, 32'h0);
        run_txn("dtlb_exl0", 0);
        set_in(1, 0, 32'h8000_0100, 0, 10'h200, 2'd0, 0, 0, 32'h1234_5678, 0, 1, 32'h0);
        run_txn("dtlb_exl1", 2);
        set_in(1, 0, 32'h8000_0200, 0, 10'h000, 2'd0, 0, 1, 32'h0, 0, 1, 32'h8000_0040);
        run_txn("eret", 1);
        set_in(1, 1, 32'h8000_0300, 0, 10'h010, 2'd0, 0, 0, 32'h0, 0, 0, 32'h0);
        run_txn("stall", 0);

        // Interrupt seen with no instruction, then attached to the next one.
        set_in(0, 0, 32'h0, 0, 10'h000, 2'd0, 0, 0, 32'h0, 1, 0, 32'h0);
        #1;
        chk("intpend.nokill", 32'(bus.mem_kill), 32'd0);
        @(posedge clk); #1;
        m_pend = 1'b1;
        set_in(1, 0, 32'h8000_3000, 0, 10'h008, 2'd0, 0, 0, 32'h0, 0, 0, 32'h0);
        run_txn("intpend", 1);
        set_in(1, 0, 32'h8000_3004, 0, 10'h000, 2'd0, 0, 0, 32'h0, 0, 0, 32'h0);
        run_txn("intclr", 0);

        // Reset while holding a redirect.
        set_in(1, 0, 32'h8000_1000, 0, 10'h010, 2'd0, 0, 0, 32'h0, 0, 0, 32'h0);
        @(posedge clk); #1;
        clr_in();
        @(posedge clk); #1;
        chk("rstmid.pre_rv", 32'(bus.redirect_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid.drop", 32'({bus.flush, bus.redirect_valid, bus.w_cp0_update_ena}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rstmid.noreplay", 32'({bus.w_cp0_update_ena, bus.redirect_valid}), 32'd0);
        end

        for (int t = 0; t < 60; t++) begin
            exc = 10'd0;
            for (int b = 0; b < 10; b++) if ($urandom_range(0, 7) == 0) exc[b] = 1'b1;
            valid = ($urandom_range(0, 5) != 0);
            stall = ($urandom_range(0, 5) == 0);
            hint  = valid && !stall && ($urandom_range(0, 7) == 0);
            set_in(valid, stall, $urandom, 1'($urandom), exc, 2'($urandom_range(0, 2)),
                   1'($urandom), 1'($urandom), $urandom, hint, 1'($urandom), $urandom);
            run_txn($sformatf("rnd%0d", t), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
